// File: rtl/plab3_mem_coherence_initiator_pkg.sv
// Shared definitions for the coherence snoop initiator: FSM encodings,
// memory-message field widths and snoop-hit classification helpers.
package plab3_mem_coherence_initiator_pkg;

    localparam int ABW   = 32;
    localparam int CLW   = 128;
    localparam int LENW  = $clog2(CLW / 8);
    localparam int TYPEW = 3;
    localparam int TESTW = 2;

    localparam logic [TYPEW-1:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [TESTW-1:0] SNOOP_HIT_TEST = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SNOOP_SEND = 3'd1,
        ST_SNOOP_WAIT = 3'd2,
        ST_MEM_REQ    = 3'd3,
        ST_MEM_WAIT   = 3'd4,
        ST_RESP       = 3'd5
    } state_t;

    typedef enum logic {
        SRC_SNOOP = 1'b0,
        SRC_MEM   = 1'b1
    } resp_src_t;

    // Only reads may be served from the peer; everything else goes to memory.
    function automatic logic is_snoop_hit(input logic [TYPEW-1:0] req_type,
                                          input logic [TESTW-1:0] resp_test);
        return (req_type == MEM_TYPE_READ) && (resp_test == SNOOP_HIT_TEST);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/plab3_mem_coherence_initiator_timer.sv
// Loadable down-counter bounding the wait for a peer snoop response.
// zero flags the decrement that brings the count to zero.
module plab3_mem_coherence_initiator_timer #(
    parameter int p_width = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [p_width-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [p_width-1:0] cnt_r;

    // Count register: load has priority, decrement stops at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != '0)) begin
            cnt_r <= cnt_r - p_width'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = dec && (cnt_r <= p_width'(1));

endmodule

// File: rtl/plab3_mem_coherence_initiator.sv
// Snoop-first memory initiator: every upstream request is snooped to the peer
// cache; peer read hits are answered locally, all else goes to main memory.
module plab3_mem_coherence_initiator
    import plab3_mem_coherence_initiator_pkg::*;
#(
    parameter int p_opaque_nbits  = 8,
    parameter int p_snoop_timeout = 16,
    localparam int REQ_NB  = TYPEW + p_opaque_nbits + ABW + LENW + CLW,
    localparam int RESP_NB = TYPEW + p_opaque_nbits + TESTW + LENW + CLW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sd,
    input  logic [REQ_NB-1:0]  upreq_msg,
    input  logic               upreq_val,
    output logic               upreq_rdy,
    output logic [RESP_NB-1:0] upresp_msg,
    output logic               upresp_val,
    input  logic               upresp_rdy,
    output logic [REQ_NB-1:0]  coherereq_msg,
    output logic               coherereq_val,
    input  logic [RESP_NB-1:0] cohereresp_msg,
    input  logic               cohereresp_val,
    output logic               cohereresp_rdy,
    output logic [REQ_NB-1:0]  memreq_msg,
    output logic               memreq_val,
    input  logic               memreq_rdy,
    input  logic [RESP_NB-1:0] memresp_msg,
    input  logic               memresp_val,
    output logic               memresp_rdy,
    output logic [15:0]        snoop_hit_cnt
);

    localparam int TW = $clog2(p_snoop_timeout);

    state_t              state_r;
    state_t              state_s;
    logic                snoop_hit_s;
    logic                timeout_s;
    logic [REQ_NB-1:0]   req_r;
    logic [CLW-1:0]      snoop_data_r;
    logic [RESP_NB-1:0]  resp_r;
    resp_src_t           src_r;
    logic [15:0]         hit_cnt_r;
    logic                upreq_rdy_r;
    logic                upresp_val_r;
    logic                coherereq_val_r;
    logic                cohereresp_rdy_r;
    logic                memreq_val_r;
    logic                memresp_rdy_r;
    logic [TESTW-1:0]    snoop_test_s;
    logic [p_opaque_nbits-1:0] req_opaque_s;
    logic                unused_s;

    assign snoop_test_s = cohereresp_msg[CLW+LENW +: TESTW];
    assign req_opaque_s = req_r[REQ_NB-TYPEW-1 -: p_opaque_nbits];

    plab3_mem_coherence_initiator_timer #(.p_width(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (state_r == ST_SNOOP_SEND),
        .load_val (TW'(p_snoop_timeout - 1)),
        .dec      (state_r == ST_SNOOP_WAIT),
        .zero     (timeout_s)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a response in the timeout cycle wins over the timeout
    always_comb begin
        state_s     = state_r;
        snoop_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (upreq_val) state_s = ST_SNOOP_SEND;
                else           state_s = ST_IDLE;
            end
            ST_SNOOP_SEND: state_s = ST_SNOOP_WAIT;
            ST_SNOOP_WAIT: begin
                if (cohereresp_val) begin
                    if (is_snoop_hit(req_r[REQ_NB-1 -: TYPEW], snoop_test_s)) begin
                        state_s     = ST_RESP;
                        snoop_hit_s = 1'b1;
                    end else begin
                        state_s = ST_MEM_REQ;
                    end
                end else if (timeout_s) begin
                    state_s = ST_MEM_REQ;
                end else begin
                    state_s = ST_SNOOP_WAIT;
                end
            end
            ST_MEM_REQ: begin
                if (memreq_rdy) state_s = ST_MEM_WAIT;
                else            state_s = ST_MEM_REQ;
            end
            ST_MEM_WAIT: begin
                if (memresp_val) state_s = ST_RESP;
                else             state_s = ST_MEM_WAIT;
            end
            ST_RESP: begin
                if (upresp_rdy) state_s = ST_IDLE;
                else            state_s = ST_RESP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Transaction message registers and response source
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_r        <= '0;
            snoop_data_r <= '0;
            resp_r       <= '0;
            src_r        <= SRC_MEM;
        end else begin
            if ((state_r == ST_IDLE) && upreq_val) begin
                req_r <= upreq_msg;
            end
            if ((state_r == ST_SNOOP_WAIT) && cohereresp_val) begin
                snoop_data_r <= cohereresp_msg[CLW-1:0];
            end
            if ((state_r == ST_MEM_WAIT) && memresp_val) begin
                resp_r <= memresp_msg;
                src_r  <= SRC_MEM;
            end else if (snoop_hit_s) begin
                src_r <= SRC_SNOOP;
            end
        end
    end

    // Saturating count of reads served by the peer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_r <= 16'd0;
        end else if (snoop_hit_s) begin
            hit_cnt_r <= sat_inc16(hit_cnt_r);
        end else begin
            hit_cnt_r <= hit_cnt_r;
        end
    end

    // Handshake outputs are registered decodes of the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upreq_rdy_r      <= 1'b1;
            upresp_val_r     <= 1'b0;
            coherereq_val_r  <= 1'b0;
            cohereresp_rdy_r <= 1'b0;
            memreq_val_r     <= 1'b0;
            memresp_rdy_r    <= 1'b0;
        end else begin
            upreq_rdy_r      <= (state_s == ST_IDLE);
            upresp_val_r     <= (state_s == ST_RESP);
            coherereq_val_r  <= (state_s == ST_SNOOP_SEND);
            cohereresp_rdy_r <= (state_s == ST_SNOOP_WAIT);
            memreq_val_r     <= (state_s == ST_MEM_REQ);
            memresp_rdy_r    <= (state_s == ST_MEM_WAIT);
        end
    end

    assign upreq_rdy      = upreq_rdy_r;
    assign upresp_val     = upresp_val_r;
    assign coherereq_val  = coherereq_val_r;
    assign cohereresp_rdy = cohereresp_rdy_r;
    assign memreq_val     = memreq_val_r;
    assign memresp_rdy    = memresp_rdy_r;
    assign coherereq_msg  = req_r;
    assign memreq_msg     = req_r;
    assign snoop_hit_cnt  = hit_cnt_r;

    assign upresp_msg = (src_r == SRC_SNOOP)
                      ? {MEM_TYPE_READ, req_opaque_s, {TESTW{1'b0}}, {LENW{1'b0}}, snoop_data_r}
                      : resp_r;

    // Security domain has no consumer here; peer header fields are not reused
    assign unused_s = ^{sd, cohereresp_msg[RESP_NB-1:CLW+LENW+TESTW],
                        cohereresp_msg[CLW+LENW-1:CLW]};

endmodule

// File: tb/tb_plab3_mem_coherence_initiator.sv
// Directed bench for the coherence snoop initiator: peer hit, peer miss,
// write invalidate, snoop timeout, backpressure, spurious inputs and reset.
module tb_plab3_mem_coherence_initiator;

    localparam logic [2:0] T_READ  = 3'd0;
    localparam logic [2:0] T_WRITE = 3'd1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sd = 1'b0;
    logic [174:0] upreq_msg = '0;
    logic         upreq_val = 1'b0;
    logic         upreq_rdy;
    logic [144:0] upresp_msg;
    logic         upresp_val;
    logic         upresp_rdy = 1'b0;
    logic [174:0] coherereq_msg;
    logic         coherereq_val;
    logic [144:0] cohereresp_msg = '0;
    logic         cohereresp_val = 1'b0;
    logic         cohereresp_rdy;
    logic [174:0] memreq_msg;
    logic         memreq_val;
    logic         memreq_rdy = 1'b0;
    logic [144:0] memresp_msg = '0;
    logic         memresp_val = 1'b0;
    logic         memresp_rdy;
    logic [15:0]  snoop_hit_cnt;

    int total = 0;
    int bad = 0;
    int memreq_hs = 0;
    int upresp_hs = 0;
    int memreq_val_cyc = 0;

    plab3_mem_coherence_initiator #(.p_opaque_nbits(8), .p_snoop_timeout(4)) dut (
        .clk(clk), .reset(reset), .sd(sd),
        .upreq_msg(upreq_msg), .upreq_val(upreq_val), .upreq_rdy(upreq_rdy),
        .upresp_msg(upresp_msg), .upresp_val(upresp_val), .upresp_rdy(upresp_rdy),
        .coherereq_msg(coherereq_msg), .coherereq_val(coherereq_val),
        .cohereresp_msg(cohereresp_msg), .cohereresp_val(cohereresp_val),
        .cohereresp_rdy(cohereresp_rdy),
        .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
        .snoop_hit_cnt(snoop_hit_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (memreq_val && memreq_rdy) memreq_hs <= memreq_hs + 1;
        if (upresp_val && upresp_rdy) upresp_hs <= upresp_hs + 1;
        if (memreq_val) memreq_val_cyc <= memreq_val_cyc + 1;
    end

    function automatic logic [174:0] mk_req(input logic [2:0] t, input logic [7:0] o,
                                            input logic [31:0] a, input logic [3:0] l,
                                            input logic [127:0] d);
        return {t, o, a, l, d};
    endfunction

    function automatic logic [144:0] mk_resp(input logic [2:0] t, input logic [7:0] o,
                                             input logic [1:0] tst, input logic [3:0] l,
                                             input logic [127:0] d);
        return {t, o, tst, l, d};
    endfunction

    // flags = {upreq_rdy, upresp_val, coherereq_val, cohereresp_rdy, memreq_val, memresp_rdy}
    task automatic test_reset();
        #1 reset = 1'b0;
        #2;
        total++;
        if ({upreq_rdy, upresp_val, coherereq_val, cohereresp_rdy, memreq_val, memresp_rdy} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=100000",
                     {upreq_rdy, upresp_val, coherereq_val, cohereresp_rdy, memreq_val, memresp_rdy});
        end
        total++;
        if ({snoop_hit_cnt, upresp_msg, memreq_msg} !== '0) begin
            bad++;
            $display("FAIL reset_regs cnt=%0h upresp=%0h memreq=%0h exp=0", snoop_hit_cnt, upresp_msg, memreq_msg);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({upreq_rdy, upresp_val, coherereq_val, cohereresp_rdy, memreq_val, memresp_rdy} !== 6'b100000) begin
            bad++;
            $display("FAIL post_reset_flags got=%b exp=100000",
                     {upreq_rdy, upresp_val, coherereq_val, cohereresp_rdy, memreq_val, memresp_rdy});
        end
    endtask

    task automatic test_snoop_hit(input logic [31:0] addr, input logic [7:0] opq,
                                  input logic [15:0] exp_cnt);
        logic [174:0] req;
        logic [127:0] d;
        int mem0;
        d = {4{32'hDEADBEEF}};
        req = mk_req(T_READ, opq, addr, 4'd0, 128'd0);
        mem0 = memreq_val_cyc;
        upreq_msg = req;
        upreq_val = 1'b1;
        @(negedge clk);
        upreq_val = 1'b0;
        total++;
        if ({coherereq_val, coherereq_msg} !== {1'b1, req}) begin
            bad++;
            $display("FAIL hit_snoop_pulse val=%b msg=%0h exp_msg=%0h", coherereq_val, coherereq_msg, req);
        end
        @(negedge clk);
        total++;
        if ({coherereq_val, cohereresp_rdy} !== 2'b01) begin
            bad++;
            $display("FAIL hit_wait_flags got=%b exp=01", {coherereq_val, cohereresp_rdy});
        end
        cohereresp_msg = mk_resp(T_READ, 8'hEE, 2'b01, 4'd0, d);
        cohereresp_val = 1'b1;
        @(negedge clk);
        cohereresp_val = 1'b0;
        total++;
        if ({upresp_val, upresp_msg} !== {1'b1, mk_resp(T_READ, opq, 2'b00, 4'd0, d)}) begin
            bad++;
            $display("FAIL hit_upresp val=%b msg=%0h exp=%0h", upresp_val, upresp_msg,
                     mk_resp(T_READ, opq, 2'b00, 4'd0, d));
        end
        total++;
        if (snoop_hit_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL hit_count got=%0d exp=%0d", snoop_hit_cnt, exp_cnt);
        end
        upresp_rdy = 1'b1;
        @(negedge clk);
        upresp_rdy = 1'b0;
        total++;
        if ({upreq_rdy, upresp_val, memreq_val_cyc} !== {2'b10, mem0}) begin
            bad++;
            $display("FAIL hit_done rdy=%b val=%b memreq_cycles=%0d exp 1 0 %0d", upreq_rdy, upresp_val,
                     memreq_val_cyc, mem0);
        end
    endtask

    // Shared shape of the memory path; snoop test code and memory reply vary per case
    task automatic test_mem_path(input string name, input logic [174:0] req,
                                 input logic [1:0] snoop_test, input logic [144:0] mresp,
                                 input logic [15:0] exp_cnt);
        upreq_msg = req;
        upreq_val = 1'b1;
        @(negedge clk);
        upreq_val = 1'b0;
        @(negedge clk);
        cohereresp_msg = mk_resp(T_READ, 8'h00, snoop_test, 4'd0, 128'hAAAA);
        cohereresp_val = 1'b1;
        @(negedge clk);
        cohereresp_val = 1'b0;
        total++;
        if ({memreq_val, memreq_msg} !== {1'b1, req}) begin
            bad++;
            $display("FAIL %s_memreq val=%b msg=%0h exp=%0h", name, memreq_val, memreq_msg, req);
        end
        memreq_rdy = 1'b1;
        @(negedge clk);
        memreq_rdy = 1'b0;
        total++;
        if ({memreq_val, memresp_rdy} !== 2'b01) begin
            bad++;
            $display("FAIL %s_memwait got=%b exp=01", name, {memreq_val, memresp_rdy});
        end
        memresp_msg = mresp;
        memresp_val = 1'b1;
        @(negedge clk);
        memresp_val = 1'b0;
        total++;
        if ({upresp_val, upresp_msg, snoop_hit_cnt} !== {1'b1, mresp, exp_cnt}) begin
            bad++;
            $display("FAIL %s_upresp val=%b msg=%0h cnt=%0d exp msg=%0h cnt=%0d", name, upresp_val,
                     upresp_msg, snoop_hit_cnt, mresp, exp_cnt);
        end
        upresp_rdy = 1'b1;
        @(negedge clk);
        upresp_rdy = 1'b0;
    endtask

    task automatic test_snoop_miss();
        test_mem_path("miss", mk_req(T_READ, 8'h11, 32'h2000, 4'd0, 128'd0), 2'b00,
                      mk_resp(T_READ, 8'h11, 2'b00, 4'd0, 128'h1234), 16'd1);
    endtask

    task automatic test_write_hit();
        test_mem_path("write", mk_req(T_WRITE, 8'h22, 32'h3000, 4'd0, 128'hCAFE), 2'b01,
                      mk_resp(T_WRITE, 8'h22, 2'b00, 4'd0, 128'd0), 16'd1);
    endtask

    task automatic test_timeout();
        logic [144:0] mresp;
        mresp = mk_resp(T_READ, 8'h44, 2'b00, 4'd0, 128'h4444);
        upreq_msg = mk_req(T_READ, 8'h44, 32'h4000, 4'd0, 128'd0);
        upreq_val = 1'b1;
        @(negedge clk);
        upreq_val = 1'b0;
        total++;
        if (coherereq_val !== 1'b1) begin
            bad++;
            $display("FAIL timeout_pulse got=%b exp=1", coherereq_val);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({memreq_val, cohereresp_rdy} !== 2'b01) begin
                bad++;
                $display("FAIL timeout_wait%0d got=%b exp=01", i, {memreq_val, cohereresp_rdy});
            end
        end
        @(negedge clk);
        total++;
        if ({memreq_val, cohereresp_rdy} !== 2'b10) begin
            bad++;
            $display("FAIL timeout_memreq got=%b exp=10", {memreq_val, cohereresp_rdy});
        end
        cohereresp_msg = mk_resp(T_READ, 8'h44, 2'b01, 4'd0, 128'hBBBB);
        cohereresp_val = 1'b1;
        memreq_rdy = 1'b1;
        @(negedge clk);
        cohereresp_val = 1'b0;
        memreq_rdy = 1'b0;
        total++;
        if ({memresp_rdy, snoop_hit_cnt} !== {1'b1, 16'd1}) begin
            bad++;
            $display("FAIL timeout_late_resp rdy=%b cnt=%0d exp 1 1", memresp_rdy, snoop_hit_cnt);
        end
        memresp_msg = mresp;
        memresp_val = 1'b1;
        @(negedge clk);
        memresp_val = 1'b0;
        total++;
        if ({upresp_val, upresp_msg} !== {1'b1, mresp}) begin
            bad++;
            $display("FAIL timeout_upresp val=%b msg=%0h exp=%0h", upresp_val, upresp_msg, mresp);
        end
        upresp_rdy = 1'b1;
        @(negedge clk);
        upresp_rdy = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [174:0] req;
        logic [144:0] mresp;
        int hs0;
        int u0;
        req = mk_req(T_READ, 8'h55, 32'h5000, 4'd0, 128'd0);
        mresp = mk_resp(T_READ, 8'h55, 2'b00, 4'd0, 128'h5555);
        hs0 = memreq_hs;
        u0 = upresp_hs;
        upreq_msg = req;
        upreq_val = 1'b1;
        @(negedge clk);
        upreq_val = 1'b0;
        @(negedge clk);
        cohereresp_msg = mk_resp(T_READ, 8'h00, 2'b00, 4'd0, 128'd0);
        cohereresp_val = 1'b1;
        @(negedge clk);
        cohereresp_val = 1'b0;
        upreq_msg = mk_req(T_WRITE, 8'h99, 32'h9999, 4'd0, 128'h9);
        upreq_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({memreq_val, upreq_rdy, memreq_msg} !== {2'b10, req}) begin
                bad++;
                $display("FAIL bp_memreq_hold%0d val=%b rdy=%b msg=%0h", i, memreq_val, upreq_rdy, memreq_msg);
            end
            @(negedge clk);
        end
        memreq_rdy = 1'b1;
        @(negedge clk);
        memreq_rdy = 1'b0;
        total++;
        if (memreq_hs !== hs0 + 1) begin
            bad++;
            $display("FAIL bp_memreq_count got=%0d exp=%0d", memreq_hs, hs0 + 1);
        end
        memresp_msg = mresp;
        memresp_val = 1'b1;
        @(negedge clk);
        memresp_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({upresp_val, upreq_rdy, upresp_msg} !== {2'b10, mresp}) begin
                bad++;
                $display("FAIL bp_upresp_hold%0d val=%b rdy=%b msg=%0h", i, upresp_val, upreq_rdy, upresp_msg);
            end
            @(negedge clk);
        end
        upresp_rdy = 1'b1;
        upreq_val = 1'b0;
        @(negedge clk);
        upresp_rdy = 1'b0;
        total++;
        if ({upresp_hs, memreq_hs, upreq_rdy, upresp_val} !== {u0 + 1, hs0 + 1, 2'b10}) begin
            bad++;
            $display("FAIL bp_done upresp_hs=%0d memreq_hs=%0d rdy=%b val=%b", upresp_hs, memreq_hs,
                     upreq_rdy, upresp_val);
        end
    endtask

    task automatic test_spurious();
        cohereresp_val = 1'b1;
        memresp_val = 1'b1;
        #1;
        total++;
        if ({cohereresp_rdy, memresp_rdy} !== 2'b00) begin
            bad++;
            $display("FAIL spurious_rdy got=%b exp=00", {cohereresp_rdy, memresp_rdy});
        end
        @(negedge clk);
        cohereresp_val = 1'b0;
        memresp_val = 1'b0;
        total++;
        if ({upreq_rdy, upresp_val, coherereq_val, cohereresp_rdy, memreq_val, memresp_rdy} !== 6'b100000) begin
            bad++;
            $display("FAIL spurious_state got=%b exp=100000",
                     {upreq_rdy, upresp_val, coherereq_val, cohereresp_rdy, memreq_val, memresp_rdy});
        end
    endtask

    task automatic test_reset_mid();
        int hs0;
        upreq_msg = mk_req(T_READ, 8'h66, 32'h6000, 4'd0, 128'd0);
        upreq_val = 1'b1;
        @(negedge clk);
        upreq_val = 1'b0;
        @(negedge clk);
        cohereresp_msg = mk_resp(T_READ, 8'h00, 2'b00, 4'd0, 128'd0);
        cohereresp_val = 1'b1;
        @(negedge clk);
        cohereresp_val = 1'b0;
        memreq_rdy = 1'b1;
        @(negedge clk);
        memreq_rdy = 1'b0;
        hs0 = memreq_hs;
        total++;
        if (memresp_rdy !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_in_memwait got=%b exp=1", memresp_rdy);
        end
        #1 reset = 1'b0;
        #1;
        total++;
        if ({upreq_rdy, upresp_val, coherereq_val, cohereresp_rdy, memreq_val, memresp_rdy, snoop_hit_cnt}
            !== {6'b100000, 16'd0}) begin
            bad++;
            $display("FAIL rstmid_async flags=%b cnt=%0d exp 100000 0",
                     {upreq_rdy, upresp_val, coherereq_val, cohereresp_rdy, memreq_val, memresp_rdy}, snoop_hit_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({memreq_hs, upreq_rdy, memreq_val} !== {hs0, 2'b10}) begin
            bad++;
            $display("FAIL rstmid_no_replay hs=%0d rdy=%b val=%b exp %0d 1 0", memreq_hs, upreq_rdy,
                     memreq_val, hs0);
        end
    endtask

    initial begin
        test_reset();
        test_snoop_hit(32'h1000, 8'h5A, 16'd1);
        test_snoop_miss();
        test_write_hit();
        test_timeout();
        test_backpressure();
        test_spurious();
        test_reset_mid();
        test_snoop_hit(32'h7000, 8'h77, 16'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
